// File: rtl/exec_alu_branch_unit_pkg.sv
// Shared constants for the execute/decode arithmetic block: datapath width,
// ALU opcodes and branch condition codes.
package exec_alu_branch_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_ADDU  = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_SUBU  = 5'd3,
    ALU_AND   = 5'd4,
    ALU_OR    = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_NOR   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_SLL   = 5'd10,
    ALU_SRL   = 5'd11,
    ALU_SRA   = 5'd12,
    ALU_MULT  = 5'd13,
    ALU_MULTU = 5'd14,
    ALU_DIV   = 5'd15,
    ALU_DIVU  = 5'd16,
    ALU_MFHI  = 5'd17,
    ALU_MFLO  = 5'd18,
    ALU_MTHI  = 5'd19,
    ALU_MTLO  = 5'd20,
    ALU_LUI   = 5'd21
  } alu_op_e;

  typedef enum logic [3:0] {
    BCU_NONE = 4'd0,
    BCU_BEQ  = 4'd1,
    BCU_BNE  = 4'd2,
    BCU_BLEZ = 4'd3,
    BCU_BGTZ = 4'd4,
    BCU_BLTZ = 4'd5,
    BCU_BGEZ = 4'd6
  } bcu_op_e;

endpackage

// File: rtl/exec_alu_branch_unit_if.sv
// Operand/result bundle between the pipeline (master) and the arithmetic block (slave).
interface exec_alu_branch_unit_if
  import exec_alu_branch_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W
);
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_result;
  logic [WIDTH-1:0] alu_src_a;
  logic [WIDTH-1:0] alu_src_b;
  logic [4:0]       sig_alu_control;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [3:0]       sig_bcu_control;
  logic [WIDTH-1:0] bcu_rd1;
  logic [WIDTH-1:0] bcu_rd2;
  logic             branch;

  modport master (
    output add_a, add_b, alu_src_a, alu_src_b, sig_alu_control,
           sig_bcu_control, bcu_rd1, bcu_rd2,
    input  add_result, alu_result, hi, lo, branch
  );

  modport slave (
    input  add_a, add_b, alu_src_a, alu_src_b, sig_alu_control,
           sig_bcu_control, bcu_rd1, bcu_rd2,
    output add_result, alu_result, hi, lo, branch
  );
endinterface

// File: rtl/exec_alu_branch_unit_wrap_adder.sv
// Plain modulo-2^WIDTH adder used for PC+4 and branch-target sums.
module wrap_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/exec_alu_branch_unit.sv
// Execute-stage ALU with HI/LO, decode-stage branch compare, and the shared adder.
// Only HI/LO hold state; everything else is combinational.
module exec_alu_branch_unit
  import exec_alu_branch_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  exec_alu_branch_unit_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   a, b;
  logic [4:0]         op;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   alu_res;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   div_b;
  logic [WIDTH-1:0]   quo_s, rem_s, quo_u, rem_u;
  logic               br;

  assign a  = bus.alu_src_a;
  assign b  = bus.alu_src_b;
  assign op = bus.sig_alu_control;

  wrap_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (bus.add_a),
    .b   (bus.add_b),
    .sum (bus.add_result)
  );

  // Sign-extending to 2*WIDTH lets one unsigned multiply give the signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // MIN / -1 is steered to MIN / 1, which yields exactly lo = MIN, hi = 0.
  assign div_zero = (b == '0);
  assign div_ovf  = (a == S_MIN) && (b == '1);
  assign div_b    = (div_zero || div_ovf) ? ONE : b;
  assign quo_s    = $signed(a) / $signed(div_b);
  assign rem_s    = $signed(a) % $signed(div_b);
  assign quo_u    = a / div_b;
  assign rem_u    = a % div_b;

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD, ALU_ADDU: alu_res = a + b;
      ALU_SUB, ALU_SUBU: alu_res = a - b;
      ALU_AND:           alu_res = a & b;
      ALU_OR:            alu_res = a | b;
      ALU_XOR:           alu_res = a ^ b;
      ALU_NOR:           alu_res = ~(a | b);
      ALU_SLT:           alu_res = ($signed(a) < $signed(b)) ? ONE : '0;
      ALU_SLTU:          alu_res = (a < b) ? ONE : '0;
      ALU_SLL:           alu_res = a << b[SH_W-1:0];
      ALU_SRL:           alu_res = a >> b[SH_W-1:0];
      ALU_SRA:           alu_res = $signed(a) >>> b[SH_W-1:0];
      ALU_MFHI:          alu_res = hi_q;
      ALU_MFLO:          alu_res = lo_q;
      ALU_LUI:           alu_res = {b[15:0], {(WIDTH-16){1'b0}}};
      default:           alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      case (op)
        ALU_MULT:  {hi_q, lo_q} <= prod_s;
        ALU_MULTU: {hi_q, lo_q} <= prod_u;
        ALU_DIV:   if (!div_zero) begin
                     hi_q <= rem_s;
                     lo_q <= quo_s;
                   end
        ALU_DIVU:  if (!div_zero) begin
                     hi_q <= rem_u;
                     lo_q <= quo_u;
                   end
        ALU_MTHI:  hi_q <= a;
        ALU_MTLO:  lo_q <= a;
        default: ;
      endcase
    end
  end

  always_comb begin
    br = 1'b0;
    case (bus.sig_bcu_control)
      BCU_BEQ:  br = (bus.bcu_rd1 == bus.bcu_rd2);
      BCU_BNE:  br = (bus.bcu_rd1 != bus.bcu_rd2);
      BCU_BLEZ: br = ($signed(bus.bcu_rd1) <= 0);
      BCU_BGTZ: br = ($signed(bus.bcu_rd1) > 0);
      BCU_BLTZ: br = ($signed(bus.bcu_rd1) < 0);
      BCU_BGEZ: br = ($signed(bus.bcu_rd1) >= 0);
      default:  br = 1'b0;
    endcase
  end

  assign bus.alu_result = alu_res;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.branch     = br;

endmodule

// File: tb/tb_exec_alu_branch_unit.sv
// Directed bench: a plain-arithmetic model checked every negedge, plus literal pins.
module tb_exec_alu_branch_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  exec_alu_branch_unit_if #(.WIDTH(32)) bus ();

  exec_alu_branch_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hv,
                                          input logic [31:0] lv);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      0, 1:    return a + b;
      2, 3:    return a - b;
      4:       return a & b;
      5:       return a | b;
      6:       return a ^ b;
      7:       return ~(a | b);
      8:       return (sa < sb) ? 32'd1 : 32'd0;
      9:       return (a < b) ? 32'd1 : 32'd0;
      10:      return a << b[4:0];
      11:      return a >> b[4:0];
      12:      return 32'(sa >>> b[4:0]);
      17:      return hv;
      18:      return lv;
      21:      return {b[15:0], 16'h0};
      default: return 32'd0;
    endcase
  endfunction

  // Returns {hi, lo} after the clock edge.
  function automatic logic [63:0] next_hilo(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hv,
                                            input logic [31:0] lv);
    int sa, sb, q, r;
    longint p;
    longint unsigned pu;
    sa = a;
    sb = b;
    case (op)
      13: begin p = longint'(sa) * longint'(sb); return p; end
      14: begin pu = {32'h0, a} * {32'h0, b}; return pu; end
      15: begin
        if (b == 0) return {hv, lv};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      16: begin
        if (b == 0) return {hv, lv};
        return {a % b, a / b};
      end
      19: return {a, lv};
      20: return {hv, b == b ? a : a};
      default: return {hv, lv};
    endcase
  endfunction

  function automatic logic exp_br(input logic [3:0] code, input logic [31:0] r1,
                                  input logic [31:0] r2);
    int s1;
    s1 = r1;
    case (code)
      1:       return r1 == r2;
      2:       return r1 != r2;
      3:       return s1 <= 0;
      4:       return s1 > 0;
      5:       return s1 < 0;
      6:       return s1 >= 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= 32'h0;
      m_lo <= 32'h0;
    end else begin
      {m_hi, m_lo} <= next_hilo(bus.sig_alu_control, bus.alu_src_a, bus.alu_src_b, m_hi, m_lo);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_add", bus.add_result, bus.add_a + bus.add_b);
      check("model_alu", bus.alu_result,
            exp_alu(bus.sig_alu_control, bus.alu_src_a, bus.alu_src_b, m_hi, m_lo));
      check("model_hi", bus.hi, m_hi);
      check("model_lo", bus.lo, m_lo);
      check("model_branch", {31'h0, bus.branch},
            {31'h0, exp_br(bus.sig_bcu_control, bus.bcu_rd1, bus.bcu_rd2)});
    end
  end

  task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.sig_alu_control = op;
    bus.alu_src_a       = a;
    bus.alu_src_b       = b;
    @(negedge clk);
  endtask

  task automatic set_bcu(input logic [3:0] code, input logic [31:0] r1, input logic [31:0] r2);
    bus.sig_bcu_control = code;
    bus.bcu_rd1         = r1;
    bus.bcu_rd2         = r2;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.add_a           = '0;
    bus.add_b           = '0;
    bus.alu_src_a       = '0;
    bus.alu_src_b       = '0;
    bus.sig_alu_control = 5'd0;
    set_bcu(4'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    bus.add_a = 32'h0040_0000; bus.add_b = 32'd4;
    set_bcu(4'd1, 32'd5, 32'd5);
    apply(5'd0, 32'h7FFF_FFFF, 32'd1);
    check("pc_plus4", bus.add_result, 32'h0040_0004);
    check("add_wrap_no_trap", bus.alu_result, 32'h8000_0000);
    check("beq_5_5", {31'h0, bus.branch}, 32'd1);

    bus.add_a = 32'hFFFF_FFFF; bus.add_b = 32'd1;
    set_bcu(4'd2, 32'd5, 32'd5);
    apply(5'd8, 32'hFFFF_FFFF, 32'd1);
    check("adder_wrap", bus.add_result, 32'h0);
    check("slt_neg1_1", bus.alu_result, 32'd1);
    check("bne_5_5", {31'h0, bus.branch}, 32'd0);

    set_bcu(4'd3, 32'h0, 32'h0);
    apply(5'd9, 32'hFFFF_FFFF, 32'd1);
    check("sltu_neg1_1", bus.alu_result, 32'd0);
    check("blez_0", {31'h0, bus.branch}, 32'd1);

    set_bcu(4'd4, 32'h8000_0000, 32'h0);
    apply(5'd12, 32'h8000_0000, 32'd4);
    check("sra_min_4", bus.alu_result, 32'hF800_0000);
    check("bgtz_min", {31'h0, bus.branch}, 32'd0);

    set_bcu(4'd6, 32'h0, 32'h0);
    apply(5'd13, 32'hFFFF_FFFD, 32'd5);
    check("mult_result_zero", bus.alu_result, 32'h0);
    check("mult_not_yet_hi", bus.hi, 32'h0);
    check("bgez_0", {31'h0, bus.branch}, 32'd1);

    set_bcu(4'd9, 32'd5, 32'd5);
    apply(5'd18, 32'h0, 32'h0);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mflo_after_mult", bus.alu_result, 32'hFFFF_FFF1);
    check("bcu_code9", {31'h0, bus.branch}, 32'd0);

    apply(5'd15, 32'd7, 32'hFFFF_FFFE);
    apply(5'd17, 32'h0, 32'h0);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("mfhi_after_div", bus.alu_result, 32'd1);

    apply(5'd15, 32'd9, 32'h0);
    apply(5'd0, 32'd3, 32'd4);
    check("div0_hi_kept", bus.hi, 32'd1);
    check("div0_lo_kept", bus.lo, 32'hFFFF_FFFD);

    apply(5'd15, 32'h8000_0000, 32'hFFFF_FFFF);
    apply(5'd18, 32'h0, 32'h0);
    check("div_ovf_lo", bus.alu_result, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0);

    apply(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    apply(5'd0, 32'h0, 32'h0);
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);

    apply(5'd19, 32'h1234_5678, 32'h0);
    check("mthi_old_hi", bus.hi, 32'hFFFF_FFFE);
    apply(5'd20, 32'hCAFE_BABE, 32'h0);
    apply(5'd17, 32'h0, 32'h0);
    check("mthi_then_mfhi", bus.alu_result, 32'h1234_5678);
    check("mtlo_lo", bus.lo, 32'hCAFE_BABE);

    apply(5'd16, 32'd100, 32'd7);
    apply(5'd21, 32'h0, 32'hABCD_1234);
    check("lui", bus.alu_result, 32'h1234_0000);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    for (int op = 2; op <= 11; op++) begin
      set_bcu(4'(op % 16), 32'hF000_0001, 32'h0000_0003);
      apply(5'(op), 32'hF0F0_1234, 32'h0000_0023);
    end
    for (int op = 22; op <= 31; op++) apply(5'(op), 32'hDEAD_BEEF, 32'h1);
    check("unused_op_hi", bus.hi, 32'd2);
    check("unused_op_lo", bus.lo, 32'd14);
    set_bcu(4'd5, 32'hFFFF_FFFF, 32'h0);
    apply(5'd4, 32'hFF00_FF00, 32'h0F0F_0F0F);
    check("and", bus.alu_result, 32'h0F00_0F00);
    check("bltz_neg1", {31'h0, bus.branch}, 32'd1);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_hi", bus.hi, 32'h0);
    check("async_reset_lo", bus.lo, 32'h0);
    apply(5'd13, 32'd3, 32'd3);
    rst_n = 1'b1;
    apply(5'd0, 32'd1, 32'd1);
    apply(5'd18, 32'h0, 32'h0);
    check("post_reset_mult", bus.alu_result, 32'd9);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
